// File: rtl/isa_pkg.sv
// isa_pkg: opcode encodings, flag bit positions and halt FSM states shared by the EX result stage.
package isa_pkg;
    localparam int DW  = 16;
    localparam int RW  = 4;
    localparam int OPW = 4;
    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_XOR    = 4'b0010;
    localparam logic [3:0] OP_RED    = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRA    = 4'b0101;
    localparam logic [3:0] OP_ROR    = 4'b0110;
    localparam logic [3:0] OP_PADDSB = 4'b0111;
    localparam logic [3:0] OP_LW     = 4'b1000;
    localparam logic [3:0] OP_SW     = 4'b1001;
    localparam logic [3:0] OP_LLB    = 4'b1010;
    localparam logic [3:0] OP_LHB    = 4'b1011;
    localparam logic [3:0] OP_B      = 4'b1100;
    localparam logic [3:0] OP_BR     = 4'b1101;
    localparam logic [3:0] OP_PCS    = 4'b1110;
    localparam logic [3:0] OP_HLT    = 4'b1111;
    localparam int FLG_Z = 0;
    localparam int FLG_V = 1;
    localparam int FLG_N = 2;
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;
endpackage

// File: rtl/flag_unit.sv
// flag_unit: combinational next-value logic for the Z/V/N flags, selected by opcode.
module flag_unit
    import isa_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [3:0]    opcode,
    input  logic [DW-1:0] result,
    input  logic          ovf,
    input  logic [2:0]    cur_flags,
    output logic [2:0]    next_flags,
    output logic          upd_en
);
    logic arith;
    logic zonly;
    assign arith = (opcode == OP_ADD) || (opcode == OP_SUB);
    assign zonly = (opcode == OP_XOR) || (opcode == OP_SLL) || (opcode == OP_SRA) || (opcode == OP_ROR);
    always_comb begin
        next_flags        = cur_flags;
        next_flags[FLG_Z] = (arith || zonly) ? ~|result : cur_flags[FLG_Z];
        next_flags[FLG_N] = arith ? result[DW-1] : cur_flags[FLG_N];
        next_flags[FLG_V] = arith ? ovf : cur_flags[FLG_V];
        upd_en            = arith || zonly;
    end
endmodule

// File: rtl/ex_result_stage.sv
// ex_result_stage: EX/MEM result register with Z/V/N flags, stall/flush handling and a halt FSM
// that drains HLT and then freezes the stage until reset.
module ex_result_stage
    import isa_pkg::*;
#(
    parameter int DW  = 16,
    parameter int RW  = 4,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [OPW-1:0] in_opcode,
    input  logic [DW-1:0]  in_result,
    input  logic           in_ovf,
    input  logic [RW-1:0]  in_dst,
    input  logic           in_wr_en,
    input  logic           stall,
    input  logic           flush,
    output logic           out_valid,
    output logic [DW-1:0]  out_result,
    output logic [RW-1:0]  out_dst,
    output logic           out_wr_en,
    output logic           flag_z,
    output logic           flag_v,
    output logic           flag_n,
    output logic           halted
);
    state_t     state;
    state_t     state_nx;
    logic [2:0] flags;
    logic [2:0] flags_nx;
    logic       upd_en;
    logic       accept;
    logic       is_hlt;

    assign accept = in_valid && !stall && !flush && (state == ST_RUN);
    assign is_hlt = (in_opcode == OP_HLT);

    flag_unit #(.DW(DW)) u_flag_unit (
        .opcode     (in_opcode),
        .result     (in_result),
        .ovf        (in_ovf),
        .cur_flags  (flags),
        .next_flags (flags_nx),
        .upd_en     (upd_en)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_RUN:   state_nx = (accept && is_hlt) ? ST_DRAIN : ST_RUN;
            ST_DRAIN: state_nx = stall ? ST_DRAIN : ST_HALTED;
            default:  state_nx = ST_HALTED;
        endcase
    end

    // A stalled edge holds everything, FSM state included, regardless of flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_dst    <= '0;
            out_wr_en  <= 1'b0;
            flags      <= '0;
        end else if (!stall) begin
            state     <= state_nx;
            out_valid <= accept;
            out_wr_en <= accept && in_wr_en && !is_hlt;
            if (accept) begin
                out_result <= in_result;
                out_dst    <= in_dst;
            end
            if (accept && upd_en)
                flags <= flags_nx;
        end
    end

    assign flag_z = flags[FLG_Z];
    assign flag_v = flags[FLG_V];
    assign flag_n = flags[FLG_N];
    assign halted = (state == ST_HALTED);
endmodule
